dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder serving the MEM stage's load/store requests.
- Accepts one request at a time on a valid/ready request channel, then waits a programmable number of wait states.
- Performs a byte-enabled word write or a full-word read, and returns the result on a valid/ready response channel.
- Replaces the combinational tristate memory model with a handshaked, multi-cycle slave. The initiator does all load sign/zero extension.

Parameters:
- ADDR_WIDTH, 9: byte address is [ADDR_WIDTH:0]; word index = addr[ADDR_WIDTH:2]; depth = 2^(ADDR_WIDTH-1) words (256 by default).
- WAIT_STATES, 1: extra cycles between request accept and memory access; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid_i  input  1  request valid
- req_ready_o  output  1  responder can accept a request
- req_we_i  input  1  1 = store, 0 = load
- req_addr_i  input  ADDR_WIDTH+1  byte address; bits [1:0] ignored
- req_be_i  input  4  byte-lane enables; bit i = bits [8i+7:8i]
- req_wdata_i  input  32  store data, already lane-aligned
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  initiator accepts the response
- rsp_rdata_o  output  32  load data, full word; 0 for stores and errors
- rsp_err_o  output  1  illegal byte-enable pattern

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, wait counter=0.
- Memory array contents are not reset. They persist across rst_n assertion.
- IDLE:
  - req_ready_o=1.
  - An accept is req_valid_i & req_ready_o at a rising edge.
  - On accept, latch we, word index, be and wdata; load counter with WAIT_STATES; go to WAIT.
- WAIT:
  - req_ready_o=0.
  - If counter != 0, decrement it.
  - If counter == 0, perform the access at this edge and go to RESP.
  - So rsp_valid_o rises WAIT_STATES+1 edges after the accept edge (2 edges at default).
- Access:
  - Load: rsp_rdata_o <= mem[idx]. be is ignored for reads.
  - Store: for each i with be[i]=1, mem[idx] byte i <= wdata byte i. rsp_rdata_o <= 0.
- RESP:
  - rsp_valid_o=1. rsp_rdata_o and rsp_err_o stay stable until handshake.
  - On rsp_valid_o & rsp_ready_i: go to IDLE; clear rsp_valid_o, rsp_rdata_o and rsp_err_o.
  - No same-cycle re-accept. Back-to-back throughput is one request per WAIT_STATES+3 cycles minimum.
- rsp_ready_i held low: remain in RESP indefinitely with outputs frozen. No request is accepted.
- Request inputs may change freely while req_ready_o=0; they are only sampled on accept.
- Legal be patterns: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Anything else is illegal (see the optional feature).
- Address wrap: none possible. All ADDR_WIDTH+1-bit addresses map into the array.
- Reset mid-operation:
  - rst_n low in WAIT cancels the in-flight request; no memory write occurs.
  - rst_n low in RESP drops the response.
  - Either way, outputs go to their reset values immediately (asynchronously).

Optional Feature:
- Macro: DMEM_BE_CHECK_EN.
- Defined:
  - An illegal be on a store sets rsp_err_o=1 in RESP, suppresses the write, and gives rsp_rdata_o=0.
  - An illegal be on a load sets rsp_err_o=1 and gives rsp_rdata_o=0.
  - Latency is unchanged.
- Undefined:
  - rsp_err_o is tied to 0.
  - Stores write exactly the lanes set in be, including be=0000, which writes nothing.
  - Loads always return the word.

Test Plan:
- Reset, then WAIT_STATES=1: store addr 0x010, be=1111, wdata 0xDEADBEEF; hold rsp_ready_i=1 -> rsp_valid_o high 2 edges after accept, rdata 0, err 0. Then load addr 0x012 -> rsp_rdata_o=0xDEADBEEF.
- Byte lane merge: after the above, store addr 0x010, be=0100, wdata 0x00AA0000 -> subsequent load returns 0xDEAABEEF.
- Response backpressure: load with rsp_ready_i=0 for 5 cycles -> rsp_valid_o stays 1, rdata stable, req_ready_o=0 throughout. Drop one cycle after rsp_ready_i=1.
- WAIT_STATES=0 and WAIT_STATES=3 builds -> rsp_valid_o rises exactly 1 and 4 edges after accept, respectively.
- Reset in WAIT: store 0x12345678 to addr 0x020 (old value 0x0), pulse rst_n low before the access edge -> outputs reset immediately; a later load of 0x020 returns 0x00000000.
- DMEM_BE_CHECK_EN defined: store be=0101 to addr 0x030 holding 0x11111111 -> rsp_err_o=1, and a later load returns 0x11111111. Macro undefined: same stimulus -> err 0, and the load returns the merged word.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Handshaked data-memory slave for the MEM stage. A request is accepted
//   in IDLE, held for WAIT_STATES extra cycles, then a byte-enabled word
//   store or a full-word load is performed. The result is presented on the
//   response channel until the initiator takes it. The initiator does all
//   load sign/zero extension.
//
//   Optional feature: define DMEM_BE_CHECK_EN to flag illegal byte-enable
//   patterns on rsp_err_o. A flagged store is suppressed and a flagged load
//   returns zero. Without the macro, rsp_err_o is always 0.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid_i  request valid
//   req_ready_o  responder can accept a request (high only in IDLE)
//   req_we_i     1 = store, 0 = load
//   req_addr_i   byte address [ADDR_WIDTH:0]; bits [1:0] are ignored
//   req_be_i     byte-lane enables; bit i covers bits [8i+7:8i]
//   req_wdata_i  lane-aligned store data
//   rsp_valid_o  response valid (high only in RESP)
//   rsp_ready_i  initiator accepts the response
//   rsp_rdata_o  load data; 0 for stores and errors
//   rsp_err_o    illegal byte-enable pattern
//
// FSM
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | request latched, counting down wait states
//   RESP  | response presented, waiting for rsp_ready_i
module dmem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH:0]   req_addr_i,
  input  logic [3:0]            req_be_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int IDX_W = ADDR_WIDTH - 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             latch;
  logic             access;
  logic             be_bad;
  logic             mem_we;

  logic [31:0] mem [DEPTH];

  // Byte offset bits never select anything: accesses are whole words.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr_i[1:0];

`ifdef DMEM_BE_CHECK_EN
  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  endfunction

  assign be_bad = !be_legal(be_q);
`else
  assign be_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    latch   = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          latch   = 1'b1;
          cnt_d   = WS_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = RESP;
          err_d   = be_bad;
          rdata_d = (!we_q && !be_bad) ? mem[idx_q] : 32'h0;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      be_q    <= 4'd0;
      wdata_q <= 32'h0;
    end else if (latch) begin
      we_q    <= req_we_i;
      idx_q   <= req_addr_i[ADDR_WIDTH:2];
      be_q    <= req_be_i;
      wdata_q <= req_wdata_i;
    end
  end

  // The array has no reset; contents survive rst_n. A reset in WAIT forces
  // state_q to IDLE, so access can never fire for a cancelled request.
  assign mem_we = access && we_q && !be_bad;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        aux_valid;
  logic        req_we;
  logic [9:0]  req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_ready;
  logic        aux_rsp_ready;

  logic        req_ready_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        rdy0, vld0, err0, rdy3, vld3, err3;
  logic [31:0] rd0, rd3;

  int n_chk  = 0;
  int n_fail = 0;

  dmem_responder #(.ADDR_WIDTH(9), .WAIT_STATES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_be_i(req_be),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
  );

  dmem_responder #(.ADDR_WIDTH(9), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(aux_valid), .req_ready_o(rdy0),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_be_i(req_be),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(vld0), .rsp_ready_i(aux_rsp_ready),
    .rsp_rdata_o(rd0), .rsp_err_o(err0)
  );

  dmem_responder #(.ADDR_WIDTH(9), .WAIT_STATES(3)) dut_ws3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(aux_valid), .req_ready_o(rdy3),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_be_i(req_be),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(vld3), .rsp_ready_i(aux_rsp_ready),
    .rsp_rdata_o(rd3), .rsp_err_o(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the main instance with rsp_ready held high.
  // lat counts rising edges from accept until rsp_valid_o is seen high.
  task automatic xact(input logic we, input logic [9:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int lat);
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready_o}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'hBAD0BAD0;
    lat = 0;
    while (rsp_valid_o !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = rsp_rdata_o;
    er = rsp_err_o;
    @(posedge clk);
    #1;
    chk("rsp_valid_drop", {31'b0, rsp_valid_o}, 32'd0);
    chk("rdata_cleared", rsp_rdata_o, 32'h0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, lat0, lat3;
  logic [31:0] exp_err, exp_word;

  initial begin
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    aux_valid     = 1'b0;
    req_we        = 1'b0;
    req_addr      = 10'h0;
    req_be        = 4'h0;
    req_wdata     = 32'h0;
    rsp_ready     = 1'b1;
    aux_rsp_ready = 1'b1;
    #1;
    chk("reset_req_ready", {31'b0, req_ready_o}, 32'd1);
    chk("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("reset_rdata", rsp_rdata_o, 32'h0);
    chk("reset_err", {31'b0, rsp_err_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-word store then load from an unaligned byte address in that word
    xact(1'b1, 10'h010, 4'b1111, 32'hDEADBEEF, rd, er, lat);
    chk("store_latency", lat, 32'd2);
    chk("store_rdata", rd, 32'h0);
    chk("store_err", {31'b0, er}, 32'd0);
    xact(1'b0, 10'h012, 4'b0000, 32'h0, rd, er, lat);
    chk("load_latency", lat, 32'd2);
    chk("load_word", rd, 32'hDEADBEEF);

    // Single-lane merge into lane 2
    xact(1'b1, 10'h010, 4'b0100, 32'h00AA0000, rd, er, lat);
    xact(1'b0, 10'h010, 4'b1111, 32'h0, rd, er, lat);
    chk("lane_merge", rd, 32'hDEAABEEF);

    // Response backpressure
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 10'h010;
    req_be    = 4'b1111;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid_o !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_latency", lat, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      chk("bp_valid_hold", {31'b0, rsp_valid_o}, 32'd1);
      chk("bp_rdata_hold", rsp_rdata_o, 32'hDEAABEEF);
      chk("bp_req_ready_low", {31'b0, req_ready_o}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_drop", {31'b0, rsp_valid_o}, 32'd0);
    chk("bp_release_idle", {31'b0, req_ready_o}, 32'd1);

    // Latency of WAIT_STATES=0 and WAIT_STATES=3 instances
    @(negedge clk);
    aux_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 10'h040;
    req_be    = 4'b1111;
    req_wdata = 32'h0;
    @(posedge clk);
    #1;
    aux_valid = 1'b0;
    lat0 = 0;
    lat3 = 0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (vld0 === 1'b1 && lat0 == 0) lat0 = e;
      if (vld3 === 1'b1 && lat3 == 0) lat3 = e;
    end
    chk("ws0_latency", lat0, 32'd1);
    chk("ws3_latency", lat3, 32'd4);

    // Reset during WAIT cancels the store
    xact(1'b1, 10'h020, 4'b1111, 32'h00000000, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 10'h020;
    req_be    = 4'b1111;
    req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("in_wait_ready_low", {31'b0, req_ready_o}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_req_ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst_wait_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("rst_wait_rdata", rsp_rdata_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 10'h020, 4'b1111, 32'h0, rd, er, lat);
    chk("rst_wait_no_write", rd, 32'h00000000);

    // Illegal byte-enable handling
`ifdef DMEM_BE_CHECK_EN
    exp_err  = 32'd1;
    exp_word = 32'h11111111;
`else
    exp_err  = 32'd0;
    exp_word = 32'h11221122;
`endif
    xact(1'b1, 10'h030, 4'b1111, 32'h11111111, rd, er, lat);
    xact(1'b1, 10'h030, 4'b0101, 32'h22222222, rd, er, lat);
    chk("be0101_store_err", {31'b0, er}, exp_err);
    chk("be0101_store_rdata", rd, 32'h0);
    chk("be0101_latency", lat, 32'd2);
    xact(1'b0, 10'h030, 4'b1111, 32'h0, rd, er, lat);
    chk("be0101_result", rd, exp_word);
    xact(1'b1, 10'h030, 4'b0000, 32'h33333333, rd, er, lat);
    chk("be0000_store_err", {31'b0, er}, exp_err);
    xact(1'b0, 10'h030, 4'b1111, 32'h0, rd, er, lat);
    chk("be0000_no_write", rd, exp_word);
    xact(1'b0, 10'h030, 4'b0101, 32'h0, rd, er, lat);
    chk("illegal_load_err", {31'b0, er}, exp_err);
`ifdef DMEM_BE_CHECK_EN
    chk("illegal_load_rdata", rd, 32'h0);
`else
    chk("illegal_load_rdata", rd, exp_word);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
